// File: rtl/instr_encode.sv
// instr_encode: packs decoded RV32I fields into 32-bit instruction words and queues them.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   field bundle handshake (in_ready is registered)
//   fmt                 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode, funct3/7    opcode and function fields
//   rd, rs1, rs2        register indices; bit 5 must be clear when the format uses them
//   imm                 full signed immediate
//   out_valid/out_ready output word handshake
//   instr, err          FIFO head word and its illegal flag (word is 0 when illegal)
//   err_count           saturating count of accepted illegal bundles
module instr_encode #(
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [6:0]           opcode,
    input  logic [5:0]           rd,
    input  logic [5:0]           rs1,
    input  logic [5:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]          enc_word;
    logic                 enc_bad;
    logic                 imm12_ok;
    logic                 imm13_ok;
    logic                 imm21_ok;

    logic [31:0]          mem_instr_q [FIFO_DEPTH];
    logic [31:0]          mem_instr_d [FIFO_DEPTH];
    logic                 mem_err_q   [FIFO_DEPTH];
    logic                 mem_err_d   [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 push;
    logic                 pop;

    // A value fits an N-bit signed field when all bits above N-1 equal the sign bit.
    // B/J offsets must also be even, which trims the top of the range to 4094 / 1048574.
    assign imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm13_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign imm21_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

    always_comb begin
        enc_word = '0;
        enc_bad  = (opcode[1:0] != 2'b11);
        case (fmt)
            3'd0: begin
                enc_word = {funct7, rs2[4:0], rs1[4:0], funct3, rd[4:0], opcode};
                enc_bad  = enc_bad | rd[5] | rs1[5] | rs2[5];
            end
            3'd1: begin
                enc_word = {imm[11:0], rs1[4:0], funct3, rd[4:0], opcode};
                enc_bad  = enc_bad | rd[5] | rs1[5] | ~imm12_ok;
            end
            3'd2: begin
                enc_word = {imm[11:5], rs2[4:0], rs1[4:0], funct3, imm[4:0], opcode};
                enc_bad  = enc_bad | rs1[5] | rs2[5] | ~imm12_ok;
            end
            3'd3: begin
                enc_word = {imm[12], imm[10:5], rs2[4:0], rs1[4:0], funct3, imm[4:1], imm[11], opcode};
                enc_bad  = enc_bad | rs1[5] | rs2[5] | ~imm13_ok;
            end
            3'd4: begin
                enc_word = {imm[31:12], rd[4:0], opcode};
                enc_bad  = enc_bad | rd[5] | (|imm[11:0]);
            end
            3'd5: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], opcode};
                enc_bad  = enc_bad | rd[5] | ~imm21_ok;
            end
            default: enc_bad = 1'b1;
        endcase
    end

    // in_ready is a flop, so a full queue refuses a push even when a pop happens in the same cycle.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    always_comb begin
        mem_instr_d = mem_instr_q;
        mem_err_d   = mem_err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_count_d = err_count_q;
        if (push) begin
            mem_instr_d[wr_ptr_q] = enc_bad ? 32'd0 : enc_word;
            mem_err_d[wr_ptr_q]   = enc_bad;
            wr_ptr_d              = wr_ptr_q + PW'(1);
            err_count_d           = (enc_bad && !(&err_count_q)) ? err_count_q + ERR_CNT_W'(1) : err_count_q;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        count_d    = count_q + CW'(push) - CW'(pop);
        in_ready_d = count_d < CW'(FIFO_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_instr_q[i] <= '0;
                mem_err_q[i]   <= 1'b0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            mem_instr_q <= mem_instr_d;
            mem_err_q   <= mem_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != '0);
    assign instr     = out_valid ? mem_instr_q[rd_ptr_q] : 32'd0;
    assign err       = out_valid & mem_err_q[rd_ptr_q];
    assign err_count = err_count_q;
endmodule

// File: tb/tb_instr_encode.sv
// tb_instr_encode: randomized and directed checks of instr_encode against a queue-based model.
module tb_instr_encode;
    localparam int DEPTH = 2;
    localparam int ECW   = 8;
    localparam int ESAT  = (1 << ECW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     fmt = '0;
    logic [6:0]     opcode = '0;
    logic [5:0]     rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]     funct3 = '0;
    logic [6:0]     funct7 = '0;
    logic [31:0]    imm = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [31:0]    instr;
    logic           err;
    logic [ECW-1:0] err_count;

    int errors = 0;
    int checks = 0;

    instr_encode #(.FIFO_DEPTH(DEPTH), .ERR_CNT_W(ECW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding: {err, word}, legality judged with signed integer ranges.
    function automatic logic [32:0] enc(input logic [2:0] f, input logic [6:0] op,
                                        input logic [5:0] d, input logic [5:0] s1, input logic [5:0] s2,
                                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        int   s = $signed(im);
        logic bad = (f > 3'd5) || (op[1:0] != 2'b11);
        logic [31:0] w = '0;
        case (f)
            3'd0: begin bad |= d[5] || s1[5] || s2[5];
                        w = {f7, s2[4:0], s1[4:0], f3, d[4:0], op}; end
            3'd1: begin bad |= d[5] || s1[5] || s < -2048 || s > 2047;
                        w = {im[11:0], s1[4:0], f3, d[4:0], op}; end
            3'd2: begin bad |= s1[5] || s2[5] || s < -2048 || s > 2047;
                        w = {im[11:5], s2[4:0], s1[4:0], f3, im[4:0], op}; end
            3'd3: begin bad |= s1[5] || s2[5] || s < -4096 || s > 4094 || (s % 2 != 0);
                        w = {im[12], im[10:5], s2[4:0], s1[4:0], f3, im[4:1], im[11], op}; end
            3'd4: begin bad |= d[5] || (s % 4096 != 0);
                        w = {im[31:12], d[4:0], op}; end
            3'd5: begin bad |= d[5] || s < -1048576 || s > 1048574 || (s % 2 != 0);
                        w = {im[20], im[10:1], im[11], im[19:12], d[4:0], op}; end
            default: ;
        endcase
        return bad ? {1'b1, 32'd0} : {1'b0, w};
    endfunction

    logic [32:0] mq[$];
    int          mcnt = 0;
    logic        mrdy = 1'b0;
    logic        last_push = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcnt = 0;
            mrdy = 1'b0;
            last_push = 1'b0;
        end else begin
            logic p, o;
            logic [32:0] e;
            p = in_valid && mrdy;
            o = (mq.size() > 0) && out_ready;
            if (o) void'(mq.pop_front());
            if (p) begin
                e = enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                mq.push_back(e);
                if (e[32] && mcnt < ESAT) mcnt++;
            end
            mrdy = mq.size() < DEPTH;
            last_push = p;
        end
    end

    always @(negedge clk) begin
        logic [32:0] h;
        h = (mq.size() > 0) ? mq[0] : 33'd0;
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mrdy));
        chk("err_count", 32'(err_count), 32'(mcnt));
        chk("instr", instr, h[31:0]);
        chk("err", 32'(err), 32'(h[32]));
    end

    task automatic set_f(input logic [2:0] f, input logic [6:0] op, input logic [5:0] d,
                         input logic [5:0] s1, input logic [5:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    // Called just after a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [2:0] f, input logic [6:0] op, input logic [5:0] d,
                        input logic [5:0] s1, input logic [5:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
        int n = 0;
        set_f(f, op, d, s1, s2, f3, f7, im);
        in_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (last_push) break;
            if (++n > 100) begin
                errors++;
                $display("FAIL push_timeout: no accept within 100 cycles, fmt=%0d", f);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic head(input string name, input logic [31:0] w, input logic e);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_instr"}, instr, w);
        chk({name, "_err"}, 32'(err), 32'(e));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        push(3'd0, 7'h33, 6'd3, 6'd1, 6'd2, 3'd0, 7'd0, 32'd0);      head("r_add", 32'h002081B3, 1'b0);
        push(3'd1, 7'h13, 6'd1, 6'd0, 6'd0, 3'd0, 7'd0, 32'hFFFFFFFF); head("i_addi", 32'hFFF00093, 1'b0);
        push(3'd2, 7'h23, 6'd0, 6'd1, 6'd2, 3'd2, 7'd0, 32'd8);      head("s_sw", 32'h0020A423, 1'b0);
        push(3'd3, 7'h63, 6'd0, 6'd0, 6'd0, 3'd0, 7'd0, -32'sd4);    head("b_beq", 32'hFE000EE3, 1'b0);
        push(3'd4, 7'h37, 6'd5, 6'd0, 6'd0, 3'd0, 7'd0, 32'h12345000); head("u_lui", 32'h123452B7, 1'b0);
        push(3'd5, 7'h6F, 6'd1, 6'd0, 6'd0, 3'd0, 7'd0, 32'h800);    head("j_jal", 32'h001000EF, 1'b0);

        push(3'd1, 7'h13, 6'd32, 6'd0, 6'd0, 3'd0, 7'd0, 32'd0);     head("bad_rd", 32'd0, 1'b1);
        chk("cnt1", 32'(err_count), 32'd1);
        push(3'd3, 7'h63, 6'd0, 6'd0, 6'd0, 3'd0, 7'd0, 32'd3);      head("bad_b_odd", 32'd0, 1'b1);
        chk("cnt2", 32'(err_count), 32'd2);
        push(3'd7, 7'h33, 6'd0, 6'd0, 6'd0, 3'd0, 7'd0, 32'd0);      head("bad_fmt", 32'd0, 1'b1);
        chk("cnt3", 32'(err_count), 32'd3);
        push(3'd1, 7'h13, 6'd1, 6'd1, 6'd0, 3'd0, 7'h7F, 32'd2047);  head("i_max_f7", 32'h7FF08093, 1'b0);
        push(3'd1, 7'h13, 6'd1, 6'd1, 6'd0, 3'd0, 7'd0, 32'd2048);   head("i_over", 32'd0, 1'b1);
        push(3'd3, 7'h63, 6'd0, 6'd0, 6'd0, 3'd0, 7'd0, 32'd4094);   head("b_max", 32'h7E000FE3, 1'b0);
        push(3'd4, 7'h37, 6'd5, 6'd0, 6'd0, 3'd0, 7'd0, 32'h1);      head("u_low", 32'd0, 1'b1);
        push(3'd5, 7'h6F, 6'd0, 6'd0, 6'd0, 3'd0, 7'd0, 32'd1048576); head("j_over", 32'd0, 1'b1);

        for (int i = 0; i < 300; i++)
            push(3'd6, 7'h33, 6'd0, 6'd0, 6'd0, 3'd0, 7'd0, 32'd0);
        chk("cnt_sat", 32'(err_count), 32'd255);

        @(negedge clk);
        out_ready = 1'b0;
        push(3'd1, 7'h13, 6'd1, 6'd0, 6'd0, 3'd0, 7'd0, 32'd1);
        push(3'd1, 7'h13, 6'd2, 6'd0, 6'd0, 3'd0, 7'd0, 32'd2);
        set_f(3'd1, 7'h13, 6'd3, 6'd0, 6'd0, 3'd0, 7'd0, 32'd3);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_full", 32'(in_ready), 32'd0);
        head("bp_head", 32'h00100093, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        head("bp_second", 32'h00200113, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_third_acc", 32'(last_push), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        head("bp_third", 32'h00300193, 1'b0);
        @(negedge clk);

        out_ready = 1'b0;
        push(3'd0, 7'h33, 6'd4, 6'd4, 6'd4, 3'd0, 7'd0, 32'd0);
        push(3'd0, 7'h33, 6'd5, 6'd5, 6'd5, 3'd0, 7'd0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(err_count), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        push(3'd0, 7'h33, 6'd3, 6'd1, 6'd2, 3'd0, 7'd0, 32'd0);
        head("after_rst", 32'h002081B3, 1'b0);

        for (int c = 0; c < 1500; c++) begin
            logic [31:0] r;
            @(negedge clk);
            in_valid = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            opcode = 7'($urandom);
            if ($urandom_range(0, 7) != 0) opcode[1:0] = 2'b11;
            rd = 6'($urandom_range(0, 31));  if ($urandom_range(0, 15) == 0) rd[5] = 1'b1;
            rs1 = 6'($urandom_range(0, 31)); if ($urandom_range(0, 15) == 0) rs1[5] = 1'b1;
            rs2 = 6'($urandom_range(0, 31)); if ($urandom_range(0, 15) == 0) rs2[5] = 1'b1;
            funct3 = 3'($urandom);
            funct7 = 7'($urandom);
            r = $urandom;
            case ($urandom_range(0, 4))
                0: imm = {{20{r[11]}}, r[11:0]};
                1: imm = {{19{r[12]}}, r[12:1], 1'b0};
                2: imm = {r[31:12], 12'd0};
                3: imm = {{11{r[20]}}, r[20:1], 1'b0};
                default: imm = r;
            endcase
            if ($urandom_range(0, 7) == 0) imm[0] = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encode.md
Name: instr_encode

Overview:
Sequential RV32I instruction encoder, the inverse of the team's op_decode block. It accepts decoded fields plus a full-width immediate through a valid/ready input. It packs them into a 32-bit instruction word and queues the result in a small output FIFO with valid/ready. Used by the self-checking CPU bench and the boot-ROM generator to synthesise instruction streams. Illegal field combinations are flagged and counted.

Parameters:
FIFO_DEPTH, 2, output queue entries; power of two, minimum 2.
ERR_CNT_W, 8, width of saturating error counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
opcode  in  7  major opcode
rd  in  6  destination register; bit5 must be 0
rs1  in  6  source 1; bit5 must be 0
rs2  in  6  source 2; bit5 must be 0
funct3  in  3  funct3
funct7  in  7  funct7, R only
imm  in  32  full signed immediate (byte offset / value)
out_valid  out  1  instr word available
out_ready  in  1  consumer takes word
instr  out  32  encoded word (FIFO head)
err  out  1  head entry was illegal
err_count  out  ERR_CNT_W  saturating count of illegal bundles accepted

Behaviour:
- Reset (async, rst_n=0): FIFO empty, out_valid=0, instr=0, err=0, err_count=0, in_ready=0 while rst_n=0. in_ready=1 from the first clk edge after release.
- Accept: in_valid&&in_ready at edge N. Entry is written at N. out_valid=1 after edge N when the FIFO was empty (1-cycle latency).
- Pop: out_valid&&out_ready at an edge removes the head.
- in_ready = (occupancy < FIFO_DEPTH), registered. It is not combinationally dependent on out_ready, so no push occurs when full even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: occupancy unchanged, order preserved. Pointers wrap modulo FIFO_DEPTH.
- instr/err hold stable while out_valid&&!out_ready.
- Packing:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
  - Register fields use bits [4:0].
- Legality: any violation marks the entry err=1 and stores instr=0.
  - fmt>5.
  - opcode[1:0]!=2'b11.
  - Bit5 set on any register used by the format: R uses rd/rs1/rs2, I uses rd/rs1, S/B use rs1/rs2, U/J use rd.
  - I/S: imm outside signed 12-bit range [-2048,2047].
  - B: imm outside [-4096,4094] or imm[0]=1.
  - U: imm[11:0]!=0.
  - J: imm outside [-1048576,1048574] or imm[0]=1.
- err_count increments on acceptance of an illegal bundle and saturates at all-ones.
- Fields of unused formats (e.g. funct7 for I) are ignored and never cause err.
- Reset asserted mid-stream discards all queued entries immediately.

Test Plan:
- R: fmt=0 op=0x33 rd=3 rs1=1 rs2=2 f3=0 f7=0 -> instr=0x002081B3, err=0, out_valid one cycle after accept.
- I/S: ADDI fmt=1 op=0x13 rd=1 rs1=0 imm=0xFFFFFFFF -> 0xFFF00093. SW fmt=2 op=0x23 f3=2 rs1=1 rs2=2 imm=8 -> 0x0020A423.
- B/U/J: BEQ fmt=3 op=0x63 imm=-4 -> 0xFE000EE3. LUI fmt=4 op=0x37 rd=5 imm=0x12345000 -> 0x123452B7. JAL fmt=5 op=0x6F rd=1 imm=0x800 -> 0x001000EF.
- Illegal cases:
  - rd=32 with fmt=1 -> err=1, instr=0, err_count=1.
  - B imm=3 -> err=1, err_count=2.
  - fmt=7 -> err_count=3.
  - 300 illegal bundles -> err_count=255.
- Backpressure: out_ready=0 with 3 pushes -> first 2 accepted, in_ready=0. Raise out_ready -> words emerge in order, in_ready returns 1 the cycle after the first pop.
- Reset mid-stream: 2 entries queued, pulse rst_n low between edges -> out_valid=0, err_count=0 immediately. The next push emerges as the first word.
